mux_arbiter_2to1: RTL and testbench

MUX_ARBITER_2TO1 -- requirements
Module: mux_arbiter_2to1

---
 rtl/arb_pkg.sv | 21 ++
 rtl/arb_burst_counter.sv | 28 ++
 rtl/mux_arbiter_2to1.sv | 155 +++++++++++++++
 tb/tb_mux_arbiter_2to1.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared types and constants for the 2:1 burst arbiter.
// State encoding, default burst length and stats helpers.
package arb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      GRANT0 = 2'b01,
      GRANT1 = 2'b10
   } arb_state_e;

   localparam int BURST_LEN_DEF = 4;
   localparam int CNT_W         = 4;
   localparam int STAT_W        = 16;

   function automatic logic [STAT_W-1:0] sat_inc(
      input logic [STAT_W-1:0] v
   );
      return (&v) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/arb_burst_counter.sv
// Burst length counter for the 2:1 arbiter.
// Flags the pop that completes a burst and wraps to zero on it.
module arb_burst_counter
   import arb_pkg::*;
#(
   parameter int BURST_LEN = BURST_LEN_DEF
) (
   input  logic clk,
   input  logic reset_L,
   input  logic i_inc,
   input  logic i_clr,
   output logic o_tc
);

   logic [CNT_W-1:0] r_cnt;

   // Terminal when the next pop would bring the count to BURST_LEN
   assign o_tc = (r_cnt == CNT_W'(BURST_LEN - 1));

   always_ff @(posedge clk) begin
      if (!reset_L || i_clr) begin
         r_cnt <= '0;
      end else if (i_inc) begin
         r_cnt <= o_tc ? '0 : r_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/mux_arbiter_2to1.sv
// Two-port burst arbiter feeding a downstream 2:1 mux.
// Define ARB_STATS_EN to add saturating per-port pop counters.
module mux_arbiter_2to1
   import arb_pkg::*;
#(
   parameter int BURST_LEN = BURST_LEN_DEF,
   parameter int WIDTH     = 8
) (
   input  logic             clk,
   input  logic             reset_L,
   input  logic             empty0,
   input  logic             empty1,
   input  logic [WIDTH-1:0] data_in0,
   input  logic [WIDTH-1:0] data_in1,
   input  logic             pause,
   output logic             pop0,
   output logic             pop1,
   output logic             selector,
   output logic [WIDTH-1:0] data_out,
   output logic             valid_bit_out
`ifdef ARB_STATS_EN
   ,
   output logic [STAT_W-1:0] grant_cnt0,
   output logic [STAT_W-1:0] grant_cnt1
`endif
);

   arb_state_e       r_state;
   arb_state_e       w_next;
   logic             r_last;
   logic             w_last_nxt;
   logic             w_clr;
   logic             w_tc;
   logic             w_pop0;
   logic             w_pop1;
   logic             r_sel;
   logic [WIDTH-1:0] r_data;
   logic             r_valid;

   assign w_pop0 = reset_L && (r_state == GRANT0)
                   && !empty0 && !pause;
   assign w_pop1 = reset_L && (r_state == GRANT1)
                   && !empty1 && !pause;

   arb_burst_counter #(
      .BURST_LEN (BURST_LEN)
   ) u_cnt (
      .clk     (clk),
      .reset_L (reset_L),
      .i_inc   (w_pop0 | w_pop1),
      .i_clr   (w_clr),
      .o_tc    (w_tc)
   );

   always_comb begin
      w_next     = r_state;
      w_last_nxt = r_last;
      w_clr      = 1'b0;
      unique case (r_state)
         IDLE: begin
            if (!empty0 && !empty1) begin
               w_next = r_last ? GRANT0 : GRANT1;
            end else if (!empty0) begin
               w_next = GRANT0;
            end else if (!empty1) begin
               w_next = GRANT1;
            end
         end
         GRANT0: begin
            if (empty0) begin
               w_clr      = 1'b1;
               w_last_nxt = 1'b0;
               w_next     = empty1 ? IDLE : GRANT1;
            end else if (w_pop0 && w_tc && !empty1) begin
               w_last_nxt = 1'b0;
               w_next     = GRANT1;
            end
         end
         GRANT1: begin
            if (empty1) begin
               w_clr      = 1'b1;
               w_last_nxt = 1'b1;
               w_next     = empty0 ? IDLE : GRANT0;
            end else if (w_pop1 && w_tc && !empty0) begin
               w_last_nxt = 1'b1;
               w_next     = GRANT0;
            end
         end
         default: begin
            w_next = IDLE;
            w_clr  = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_L) begin
         r_state <= IDLE;
         r_last  <= 1'b1;
      end else begin
         r_state <= w_next;
         r_last  <= w_last_nxt;
      end
   end

   // Selector trails the state register by one cycle, holds in IDLE
   always_ff @(posedge clk) begin
      if (!reset_L) begin
         r_sel <= 1'b0;
      end else if (r_state == GRANT0) begin
         r_sel <= 1'b0;
      end else if (r_state == GRANT1) begin
         r_sel <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_L) begin
         r_data  <= '0;
         r_valid <= 1'b0;
      end else begin
         r_valid <= w_pop0 | w_pop1;
         if (w_pop0) begin
            r_data <= data_in0;
         end else if (w_pop1) begin
            r_data <= data_in1;
         end
      end
   end

   assign pop0          = w_pop0;
   assign pop1          = w_pop1;
   assign selector      = r_sel;
   assign data_out      = r_data;
   assign valid_bit_out = r_valid;

`ifdef ARB_STATS_EN
   logic [STAT_W-1:0] r_gc0;
   logic [STAT_W-1:0] r_gc1;

   always_ff @(posedge clk) begin
      if (!reset_L) begin
         r_gc0 <= '0;
         r_gc1 <= '0;
      end else begin
         if (w_pop0) r_gc0 <= sat_inc(r_gc0);
         if (w_pop1) r_gc1 <= sat_inc(r_gc1);
      end
   end

   assign grant_cnt0 = r_gc0;
   assign grant_cnt1 = r_gc1;
`endif

endmodule

// File: tb/tb_mux_arbiter_2to1.sv
// Self-checking bench for mux_arbiter_2to1 with a behavioural model.
// Directed scenarios followed by randomized traffic.
module tb_mux_arbiter_2to1;

   localparam int BL = 4;
   localparam int W  = 8;

   logic         clk = 1'b0;
   logic         reset_L;
   logic         empty0, empty1, pause;
   logic [W-1:0] data_in0, data_in1;
   logic         pop0, pop1, selector, valid_bit_out;
   logic [W-1:0] data_out;
`ifdef ARB_STATS_EN
   logic [15:0]  grant_cnt0, grant_cnt1;
`endif

   always #5 clk = ~clk;

   mux_arbiter_2to1 #(
      .BURST_LEN (BL),
      .WIDTH     (W)
   ) dut (
      .clk           (clk),
      .reset_L       (reset_L),
      .empty0        (empty0),
      .empty1        (empty1),
      .data_in0      (data_in0),
      .data_in1      (data_in1),
      .pause         (pause),
      .pop0          (pop0),
      .pop1          (pop1),
      .selector      (selector),
      .data_out      (data_out),
      .valid_bit_out (valid_bit_out)
`ifdef ARB_STATS_EN
      ,
      .grant_cnt0    (grant_cnt0),
      .grant_cnt1    (grant_cnt1)
`endif
   );

   int vectors     = 0;
   int miscompares = 0;

   // Model: g = granted port (-1 idle), n = pops in burst, ls = last served
   int           g, n, ls;
   int           m_gc0, m_gc1;
   logic         m_valid, m_sel;
   logic [W-1:0] m_data;
   int           n_pop0;
   int           obs_q[$];

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      vectors++;
      assert (got === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      g = -1; n = 0; ls = 1;
      m_valid = 1'b0; m_sel = 1'b0; m_data = '0;
      m_gc0 = 0; m_gc1 = 0;
   endtask

   function automatic int exp_pop(input logic rl, e0, e1, p);
      if (!rl || p || g < 0) return -1;
      if (g == 0 && !e0) return 0;
      if (g == 1 && !e1) return 1;
      return -1;
   endfunction

   task automatic model_update(input logic rl, e0, e1, p,
                               input logic [W-1:0] d0, d1,
                               input int ep);
      int emp[2];
      int o;
      if (!rl) begin
         model_reset();
         return;
      end
      emp[0] = int'(e0);
      emp[1] = int'(e1);
      m_valid = (ep >= 0);
      if (ep == 0) m_data = d0;
      if (ep == 1) m_data = d1;
      if (ep == 0 && m_gc0 < 65535) m_gc0++;
      if (ep == 1 && m_gc1 < 65535) m_gc1++;
      if (g == 0) m_sel = 1'b0;
      if (g == 1) m_sel = 1'b1;
      if (g < 0) begin
         if (!e0 && !e1) g = 1 - ls;
         else if (!e0) g = 0;
         else if (!e1) g = 1;
      end else begin
         o = 1 - g;
         if (emp[g] != 0) begin
            n  = 0;
            ls = g;
            g  = (emp[o] == 0) ? o : -1;
         end else if (!p) begin
            n++;
            if (n == BL) begin
               n = 0;
               if (emp[o] == 0) begin
                  ls = g;
                  g  = o;
               end
            end
         end
      end
   endtask

   task automatic cyc(input logic rl, e0, e1, p,
                      input logic [W-1:0] d0, d1);
      int ep;
      @(negedge clk);
      reset_L  = rl;
      empty0   = e0;
      empty1   = e1;
      pause    = p;
      data_in0 = d0;
      data_in1 = d1;
      #1;
      ep = exp_pop(rl, e0, e1, p);
      chk("pop0", 32'(pop0), 32'(ep == 0));
      chk("pop1", 32'(pop1), 32'(ep == 1));
      chk("valid", 32'(valid_bit_out), 32'(m_valid));
      chk("data", 32'(data_out), 32'(m_data));
      chk("selector", 32'(selector), 32'(m_sel));
`ifdef ARB_STATS_EN
      chk("gcnt0", 32'(grant_cnt0), 32'(m_gc0));
      chk("gcnt1", 32'(grant_cnt1), 32'(m_gc1));
`endif
      if (pop0) begin n_pop0++; obs_q.push_back(0); end
      if (pop1) obs_q.push_back(1);
      model_update(rl, e0, e1, p, d0, d1, ep);
   endtask

   initial begin
      int pat[9];
      pat = '{0, 0, 0, 0, 1, 1, 1, 1, 0};
      reset_L = 1'b0; empty0 = 1'b1; empty1 = 1'b1; pause = 1'b0;
      data_in0 = '0; data_in1 = '0;
      repeat (2) @(posedge clk);
      model_reset();

      // Port 0 alone: six words in order
      cyc(1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00);
      n_pop0 = 0;
      for (int i = 0; i < 12; i++) begin
         cyc(1'b1, (n_pop0 >= 6), 1'b1, 1'b0,
             8'(8'h11 + n_pop0), 8'h00);
      end
      chk("six_pops", 32'(n_pop0), 32'd6);

      // Both busy: alternating bursts after a fresh reset
      cyc(1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00);
      obs_q.delete();
      for (int i = 0; i < 12; i++) begin
         cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'($urandom), 8'($urandom));
      end
      chk("pat_len", 32'(obs_q.size() >= 9), 32'd1);
      for (int i = 0; i < 9 && i < obs_q.size(); i++) begin
         chk("burst_pat", 32'(obs_q[i]), 32'(pat[i]));
      end

      // Pause for three cycles after two pops
      cyc(1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00);
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'h20, 8'h40);
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'h21, 8'h40);
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'h22, 8'h40);
      repeat (3) cyc(1'b1, 1'b0, 1'b0, 1'b1, 8'h23, 8'h41);
      obs_q.delete();
      repeat (4) cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'h24, 8'h42);
      chk("post_pause", 32'(obs_q.size() == 4 && obs_q[1] == 0
                            && obs_q[2] == 1), 32'd1);

      // Port 0 drains after one pop, then both empty, then both busy
      cyc(1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00);
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'h50, 8'h60);
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'h50, 8'h60);
      repeat (3) cyc(1'b1, 1'b1, 1'b0, 1'b0, 8'h51, 8'h61);
      repeat (3) cyc(1'b1, 1'b1, 1'b1, 1'b0, 8'h52, 8'h62);
      repeat (4) cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'h53, 8'h63);

      // Reset in GRANT1 after two pops
      cyc(1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00);
      repeat (7) cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'h70, 8'h71);
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 8'h72, 8'h73);
      repeat (4) cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'h74, 8'h75);

      // Randomized traffic with occasional resets
      for (int i = 0; i < 600; i++) begin
         cyc(($urandom % 64) != 0, ($urandom % 4) == 0,
             ($urandom % 4) == 0, ($urandom % 5) == 0,
             8'($urandom), 8'($urandom));
      end

`ifdef ARB_STATS_EN
      cyc(1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00);
      for (int i = 0; i < 70000; i++) begin
         cyc(1'b1, 1'b0, 1'b1, 1'b0, 8'($urandom), 8'h00);
      end
      cyc(1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00);
      chk("gcnt0_sat", 32'(grant_cnt0), 32'h0000FFFF);
`endif

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule
